sha256_msg_driver: RTL and testbench
====================================

Name: sha256_msg_driver

Overview:
- Initiator side of the SHA-256 compression core interface (start / w[16] / hash_in[8] / hash_out[8] / hash_done).
- Reads a NUM_OF_WORDS-word message from the shared word memory and applies word-granular SHA-256 padding.
- Issues one 512-bit block at a time to the core, chaining each block's hash into the next, then writes the 8-word digest back to memory.
- Sits between the top-level controller and the compression core.

Parameters:
NUM_OF_WORDS, 20, message length in 32-bit words; legal range 1..1024.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
message_addr  in  16  word address of message word 0
output_addr  in  16  word address where digest word 0 is written
done  out  1  one-cycle pulse after the last digest write
digest  out  32x8  final hash, held until the next accepted start
mem_we  out  1  memory write enable
mem_addr  out  16  memory word address
mem_write_data  out  32  memory write data
mem_read_data  in  32  memory read data, valid the cycle after mem_addr
core_start  out  1  start pulse to the compression core
core_w  out  32x16  block words to the core
core_hash_in  out  32x8  chaining hash to the core
core_hash_out  in  32x8  core result, valid when core_done=1
core_done  in  1  core completion pulse

Behaviour:
- Reset values: done=0, mem_we=0, mem_addr=0, mem_write_data=0, core_start=0, core_w=0, core_hash_in=0, digest=0. State goes to IDLE; counters clear.
- Integration: the core's reset_n is tied to ~reset, so both blocks reset together. A reset mid-operation abandons the message; no stale core_done is ever awaited.
- NB = ceil((NUM_OF_WORDS+3)/16) blocks. For global word g = 16*b + j:
  - g < N: mem[message_addr+g]
  - g == N: 0x80000000
  - g == 16*NB-2: 0
  - g == 16*NB-1: N*32
  - otherwise: 0
- H is initialised on accepted start to 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19.
- IDLE: start=1 latches message_addr and output_addr, initialises H, sets b=0 and j=0, then goes to READ. start is ignored in every other state.
- READ takes exactly 17 cycles per block.
  - Cycle k (k=0..15) drives mem_addr = message_addr + 16b + k, mem_we=0.
  - Cycle k+1 loads core_w[k] with mem_read_data if g<N, otherwise with the pad value.
  - After the 17th cycle, go to ISSUE.
- ISSUE: core_start=1 for exactly one cycle with core_hash_in=H. core_w and core_hash_in stay stable from ISSUE until core_done. Next state is WAIT.
- WAIT: core_start=0. core_done is ignored in every other state.
  - On core_done: H <= core_hash_out (the core already adds the chaining input).
  - If b < NB-1: b <= b+1, go to READ. The next READ begins the cycle after core_done; the core's one-cycle post-done buffer is covered by READ's 17 cycles.
  - Else: digest <= core_hash_out, go to WRITE.
- WRITE: 8 consecutive cycles, mem_we=1, mem_addr = output_addr+i, mem_write_data = H[i] for i=0..7. Then DONE.
- DONE: done=1 for one cycle, mem_we=0, return to IDLE. A start in the DONE cycle is ignored; start is accepted from the following cycle.
- Address arithmetic is 16-bit and wraps modulo 2^16.
- Length word is N*32 in 32 bits; the high length word is always 0.

Test Plan:
- N=20, mem[i]=i+1 -> two ISSUE pulses.
  - Block 0: core_w[k]=k+1, core_hash_in = initial H.
  - Block 1: core_w[0..3]=17..20, core_w[4]=0x80000000, core_w[5..14]=0, core_w[15]=0x00000280.
  - Digest matches the software SHA-256 of the 80-byte message.
- N=13 -> one block; core_w[13]=0x80000000, core_w[14]=0, core_w[15]=0x000001A0; 8 writes at output_addr..+7, then done pulses the next cycle.
- N=14 -> two blocks.
  - Block 0: core_w[14]=0x80000000, core_w[15]=0.
  - Block 1: core_w[0..14]=0, core_w[15]=0x000001C0.
- Second block's core_hash_in equals the first core_hash_out; start pulsed during WAIT and WRITE is ignored (exactly NB core_start pulses, one done).
- reset=1 for one cycle during WAIT of block 0 -> all outputs return to reset values. A fresh start then reproduces the first-scenario digest exactly.
- message_addr=0xFFF8, N=20 -> reads wrap to addresses 0x0000..0x000B; output_addr=0xFFFC -> writes at FFFC..FFFF, then 0000..0003.

Source files
------------

// File: rtl/sha256_msg_driver.sv
// SHA-256 message driver: fetches a message from shared word memory, applies word-granular
// padding, feeds the compression core one block at a time and writes the chained digest back.
module sha256_msg_driver #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       message_addr,
  input  logic [15:0]       output_addr,
  output logic              done,
  output logic [7:0][31:0]  digest,
  output logic              mem_we,
  output logic [15:0]       mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic              core_start,
  output logic [15:0][31:0] core_w,
  output logic [7:0][31:0]  core_hash_in,
  input  logic [7:0][31:0]  core_hash_out,
  input  logic              core_done
);

  localparam int NB = (NUM_OF_WORDS + 3 + 15) / 16;
  localparam logic [15:0] MSG_WORDS = 16'(NUM_OF_WORDS);
  localparam logic [15:0] LEN_IDX   = 16'(16 * NB - 1);
  localparam logic [31:0] LEN_BITS  = 32'(NUM_OF_WORDS * 32);
  localparam logic [6:0]  LAST_BLK  = 7'(NB - 1);
  localparam logic [7:0][31:0] H_INIT = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_r, state_next_s;
  logic [15:0]      msg_base_r, out_base_r;
  logic [6:0]       blk_r;
  logic [4:0]       rd_cnt_r;
  logic [2:0]       wr_cnt_r;
  logic [7:0][31:0] h_r;
  logic [15:0]      blk_base_s, glob_idx_s;
  logic [3:0]       word_idx_s;

  // Message word g of the padded stream: memory data, the 0x80000000 marker, the bit length or zero.
  function automatic logic [31:0] pad_word(input logic [15:0] g, input logic [31:0] rd);
    logic [31:0] w;
    if (g < MSG_WORDS)       w = rd;
    else if (g == MSG_WORDS) w = 32'h8000_0000;
    else if (g == LEN_IDX)   w = LEN_BITS;
    else                     w = 32'h0000_0000;
    return w;
  endfunction

  // Read data arrives one cycle after its address, so READ cycle k+1 stores word k.
  assign blk_base_s = {5'd0, blk_r, 4'd0};
  assign word_idx_s = 4'(rd_cnt_r - 5'd1);
  assign glob_idx_s = blk_base_s + {12'd0, word_idx_s};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_next_s;
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE:  if (start) state_next_s = S_READ; else state_next_s = S_IDLE;
      S_READ:  if (rd_cnt_r == 5'd16) state_next_s = S_ISSUE; else state_next_s = S_READ;
      S_ISSUE: state_next_s = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          if (blk_r < LAST_BLK) state_next_s = S_READ;
          else                  state_next_s = S_WRITE;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_WRITE: if (wr_cnt_r == 3'd7) state_next_s = S_DONE; else state_next_s = S_WRITE;
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; each output is set up one cycle ahead of the state that shows it.
  always_ff @(posedge clk) begin
    if (reset) begin
      done           <= 1'b0;
      digest         <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= 16'd0;
      mem_write_data <= 32'd0;
      core_start     <= 1'b0;
      core_w         <= '0;
      core_hash_in   <= '0;
      msg_base_r     <= 16'd0;
      out_base_r     <= 16'd0;
      blk_r          <= 7'd0;
      rd_cnt_r       <= 5'd0;
      wr_cnt_r       <= 3'd0;
      h_r            <= '0;
    end else begin
      core_start <= 1'b0;
      done       <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            msg_base_r <= message_addr;
            out_base_r <= output_addr;
            h_r        <= H_INIT;
            blk_r      <= 7'd0;
            rd_cnt_r   <= 5'd0;
            wr_cnt_r   <= 3'd0;
            mem_addr   <= message_addr;
          end
        end
        S_READ: begin
          if (rd_cnt_r < 5'd15) mem_addr <= msg_base_r + blk_base_s + {11'd0, rd_cnt_r} + 16'd1;
          if (rd_cnt_r != 5'd0) core_w[word_idx_s] <= pad_word(glob_idx_s, mem_read_data);
          if (rd_cnt_r == 5'd16) begin
            core_start   <= 1'b1;
            core_hash_in <= h_r;
          end
          rd_cnt_r <= rd_cnt_r + 5'd1;
        end
        S_ISSUE: begin
        end
        S_WAIT: begin
          if (core_done) begin
            h_r <= core_hash_out;
            if (blk_r < LAST_BLK) begin
              blk_r    <= blk_r + 7'd1;
              rd_cnt_r <= 5'd0;
              mem_addr <= msg_base_r + blk_base_s + 16'd16;
            end else begin
              digest         <= core_hash_out;
              mem_we         <= 1'b1;
              mem_addr       <= out_base_r;
              mem_write_data <= core_hash_out[0];
              wr_cnt_r       <= 3'd0;
            end
          end
        end
        S_WRITE: begin
          if (wr_cnt_r == 3'd7) begin
            mem_we <= 1'b0;
            done   <= 1'b1;
          end else begin
            mem_addr       <= out_base_r + {13'd0, wr_cnt_r} + 16'd1;
            mem_write_data <= h_r[wr_cnt_r + 3'd1];
            wr_cnt_r       <= wr_cnt_r + 3'd1;
          end
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_driver.sv
// Scoreboard bench for sha256_msg_driver: three instances (N=20, 13, 14) against a behavioural
// SHA-256 core and a padding/chaining reference model built from the message rules.
module tb_sha256_msg_driver;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [7:0][31:0] H0 = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One SHA-256 compression including the final chaining addition.
  function automatic logic [7:0][31:0] sha_compress(input logic [7:0][31:0] h, input logic [15:0][31:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] v [0:7];
    logic [31:0] s0, s1, ch, mj, t1, t2;
    logic [7:0][31:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = h[i];
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
      ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
      t1 = v[7] + s1 + ch + K[i] + w[i];
      s0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
      mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t2 = s0 + mj;
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[i] = h[i] + v[i];
    return r;
  endfunction

  task automatic check(input bit ok, input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int NW = (gi == 0) ? 20 : ((gi == 1) ? 13 : 14);
    localparam int NB = (NW + 3 + 15) / 16;

    logic              reset, start, done, mem_we, core_start, core_done;
    logic [15:0]       message_addr, output_addr, mem_addr;
    logic [31:0]       mem_write_data, mem_read_data;
    logic [7:0][31:0]  digest, core_hash_in, core_hash_out;
    logic [15:0][31:0] core_w;
    logic [31:0]       mem [0:65535];
    logic [15:0][31:0] exp_w_q [$];
    logic [7:0][31:0]  exp_h_q [$];
    logic [47:0]       exp_wr_q [$];
    logic [7:0][31:0]  exp_digest;
    int                done_cnt = 0;
    bit                fin = 1'b0;

    sha256_msg_driver #(.NUM_OF_WORDS(NW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .message_addr(message_addr), .output_addr(output_addr),
      .done(done), .digest(digest),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .core_start(core_start), .core_w(core_w), .core_hash_in(core_hash_in),
      .core_hash_out(core_hash_out), .core_done(core_done)
    );

    always @(posedge clk) mem_read_data <= mem[mem_addr];

    // Reference model: padded blocks, chaining hashes, write-back stream and digest.
    task automatic expect_msg();
      logic [7:0][31:0]  h;
      logic [15:0][31:0] w;
      int g;
      h = H0;
      for (int b = 0; b < NB; b++) begin
        for (int j = 0; j < 16; j++) begin
          g = 16 * b + j;
          if (g < NW)              w[j] = mem[16'(int'(message_addr) + g)];
          else if (g == NW)        w[j] = 32'h8000_0000;
          else if (g == 16*NB - 1) w[j] = 32'(NW * 32);
          else                     w[j] = 32'd0;
        end
        exp_w_q.push_back(w);
        exp_h_q.push_back(h);
        h = sha_compress(h, w);
      end
      for (int i = 0; i < 8; i++) exp_wr_q.push_back({16'(int'(output_addr) + i), h[i]});
      exp_digest = h;
    endtask

    task automatic fill(input logic [15:0] base, input bit counting);
      for (int i = 0; i < NW; i++) mem[16'(int'(base) + i)] = counting ? 32'(i + 1) : $urandom;
    endtask

    task automatic check_reset_vals();
      check(done == 1'b0 && mem_we == 1'b0 && core_start == 1'b0, "reset_ctl", {done, mem_we, core_start}, 512'd0);
      check(mem_addr == 16'd0 && mem_write_data == 32'd0, "reset_mem", {mem_addr, mem_write_data}, 512'd0);
      check(core_w == '0, "reset_core_w", core_w, 512'd0);
      check(core_hash_in == '0 && digest == '0, "reset_hash", {core_hash_in, digest}, 512'd0);
    endtask

    task automatic run_msg(input logic [15:0] ma, input logic [15:0] oa);
      int cyc;
      int d0;
      d0 = done_cnt;
      message_addr = ma;
      output_addr  = oa;
      expect_msg();
      start = 1'b1;
      @(negedge clk);
      cyc = 0;
      while (!done && cyc < 3000) begin
        start        = ($urandom_range(0, 7) == 0);
        message_addr = 16'($urandom);
        output_addr  = 16'($urandom);
        @(negedge clk);
        cyc++;
      end
      check(done == 1'b1, "done_timeout", cyc, 3000);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check(done_cnt == d0 + 1, "done_count", done_cnt - d0, 1);
      check(digest == exp_digest, "digest_hold", digest, exp_digest);
    endtask

    // Behavioural compression core with random latency; checks every issued block.
    initial begin
      bit busy;
      int lat;
      logic [7:0][31:0] res;
      busy = 1'b0; lat = 0; res = '0;
      core_done = 1'b0; core_hash_out = '0;
      forever begin
        @(posedge clk); #1;
        core_done = 1'b0;
        if (reset) begin
          busy = 1'b0;
        end else if (busy) begin
          if (lat == 0) begin
            core_hash_out = res;
            core_done = 1'b1;
            busy = 1'b0;
          end else begin
            lat--;
          end
        end else if (core_start) begin
          if (exp_w_q.size() == 0) begin
            check(1'b0, "unexpected_core_start", core_w, 512'd0);
          end else begin
            check(core_w == exp_w_q[0], "core_w", core_w, exp_w_q[0]);
            check(core_hash_in == exp_h_q[0], "core_hash_in", core_hash_in, exp_h_q[0]);
            void'(exp_w_q.pop_front());
            void'(exp_h_q.pop_front());
          end
          res  = sha_compress(core_hash_in, core_w);
          lat  = $urandom_range(0, 4);
          busy = 1'b1;
        end
      end
    end

    // Output monitor: write-back stream, done timing and digest.
    initial begin
      bit prev_we;
      logic [47:0] e;
      prev_we = 1'b0;
      forever begin
        @(negedge clk);
        if (!reset && mem_we) begin
          if (exp_wr_q.size() == 0) begin
            check(1'b0, "unexpected_write", {mem_addr, mem_write_data}, 512'd0);
          end else begin
            e = exp_wr_q.pop_front();
            check({mem_addr, mem_write_data} == e, "write", {mem_addr, mem_write_data}, e);
          end
        end
        if (!reset && done) begin
          done_cnt++;
          check(digest == exp_digest, "digest", digest, exp_digest);
          check(prev_we && exp_wr_q.size() == 0 && exp_w_q.size() == 0, "done_timing",
                {prev_we, 32'(exp_wr_q.size()), 32'(exp_w_q.size())}, {1'b1, 64'd0});
        end
        prev_we = mem_we;
      end
    end

    // Stimulus sequence.
    initial begin
      logic [7:0][31:0] d1;
      logic [15:0] base;
      int cyc;
      reset = 1'b1; start = 1'b0; message_addr = 16'd0; output_addr = 16'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_reset_vals();

      fill(16'h0100, 1'b1);
      run_msg(16'h0100, 16'h2000);
      d1 = exp_digest;

      // Reset while waiting on block 0, then a clean rerun of the same message.
      message_addr = 16'h0100;
      output_addr  = 16'h2000;
      expect_msg();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!core_start && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check(core_start == 1'b1, "issue_timeout", cyc, 100);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_w_q.delete(); exp_h_q.delete(); exp_wr_q.delete();
      check_reset_vals();
      run_msg(16'h0100, 16'h2000);
      check(digest == d1, "rerun_digest", digest, d1);

      fill(16'hFFF8, 1'b0);
      run_msg(16'hFFF8, 16'hFFFC);

      repeat (3) begin
        base = 16'($urandom);
        fill(base, 1'b0);
        run_msg(base, 16'($urandom));
      end
      fin = 1'b1;
    end
  end

  initial begin
    logic [15:0][31:0] blk;
    logic [7:0][31:0]  kat_exp, kat_act;
    int cyc;
    blk = '0;
    blk[0]  = 32'h6162_6380;
    blk[15] = 32'h0000_0018;
    kat_exp = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
               32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
    kat_act = sha_compress(H0, blk);
    check(kat_act == kat_exp, "model_kat_abc", kat_act, kat_exp);
    cyc = 0;
    while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) && cyc < 50000) begin
      @(posedge clk);
      cyc++;
    end
    check(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin, "global_timeout", cyc, 50000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
